ram_arbiter: RTL and testbench

Round-robin arbiter sharing the single-port 512×32 data RAM between up to four requesters (instruction fetch, load/store unit, debug/loader port). Each requester gets a valid/ready request channel and a one-cycle-later response strobe. The arbiter drives the RAM's enable/write/address/data ports directly. It supports a lock so one requester can hold the RAM across back-to-back accesses, for example read-modify-write.

---
 rtl/ram_pkg.sv | 16 +
 rtl/rr_grant.sv | 44 ++++
 rtl/ram_arbiter.sv | 142 ++++++++++++++
 tb/tb_ram_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared constants and types for the data-RAM arbiter slice.
//   RAM_ADDR_BITS / RAM_WIDTH : geometry of the 512x32 data RAM.
//   MAX_REQ                   : largest supported requester count.
//   IDX_W                     : width of a requester index / round-robin pointer.
//   arb_state_e               : arbiter FSM states.
package ram_pkg;
    localparam int RAM_ADDR_BITS = 9;
    localparam int RAM_WIDTH     = 32;
    localparam int MAX_REQ       = 4;
    localparam int IDX_W         = $clog2(MAX_REQ);

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;
endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin priority picker.
//   req : request vector, one bit per requester.
//   ptr : index with highest priority; the scan goes upward from here and wraps.
//   gnt : one-hot grant (all zero when no request is set).
//   idx : encoded index of the granted requester (0 when none).
//   any : at least one request is set.
module rr_grant
    import ram_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic found;

    // Two passes give the wrapped scan order: first the requesters at or
    // above the pointer, then the ones below it.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (IDX_W'(i) >= ptr)) begin
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
                found  = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one single-port RAM between
// NUM_REQ requesters, with an optional lock for back-to-back ownership.
//   clock, reset          : rising-edge clock, asynchronous active-high reset.
//   req_valid/req_ready   : per-requester request channel.
//   req_we/req_lock       : write flag; keep ownership after this transfer.
//   req_addr/req_wdata    : packed per-requester address / write data.
//   rsp_valid/rsp_rdata   : one-hot response strobe one cycle after a transfer;
//                           shared read data straight from the RAM.
//   ram_*                 : RAM port (registered read-first RAM).
//   dbg_state/dbg_rr_ptr  : FSM state and round-robin pointer for observation.
//
// Handshake: a transfer happens on a rising edge where req_valid[i] &&
// req_ready[i]. req_ready depends only on req_valid and internal state, never
// on another requester's ready. A requester must hold its addr/wdata/we/lock
// stable while valid && !ready. Responses cannot be back-pressured.
module ram_arbiter
    import ram_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_BITS  = RAM_ADDR_BITS,
    parameter int DATA_WIDTH = RAM_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_BITS-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          ram_enable,
    output logic                          ram_we,
    output logic [ADDR_BITS-1:0]          ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    input  logic [DATA_WIDTH-1:0]         ram_rdata,
    output arb_state_e                    dbg_state,
    output logic [IDX_W-1:0]              dbg_rr_ptr
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0] rsp_pend_q, rsp_pend_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   g_idx;
    logic               g_lock;
    logic               xfer;

    rr_grant #(.N(NUM_REQ)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        owner_oh   = '0;
        grant      = '0;
        g_idx      = '0;
        g_lock     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        rsp_pend_d = '0;

        for (int i = 0; i < NUM_REQ; i++) begin
            owner_oh[i] = (owner_q == IDX_W'(i));
        end

        // While locked only the owner may be granted, whatever its priority.
        case (state_q)
            ARB_IDLE:   grant = pick_any ? pick_gnt : '0;
            ARB_LOCKED: grant = owner_oh & req_valid;
            default:    grant = '0;
        endcase
        // Ready is combinational, so it is forced off while reset is held.
        if (reset) begin
            grant = '0;
        end

        // Port mux: grant is one-hot or zero, so at most one slot drives.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                g_idx     = IDX_W'(i);
                g_lock    = req_lock[i];
                ram_we    = req_we[i];
                ram_addr  = req_addr[i*ADDR_BITS +: ADDR_BITS];
                ram_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        xfer = |grant;

        if (xfer) begin
            rsp_pend_d = grant;
            // Only the transfer taken from IDLE moves the pointer; later
            // transfers inside a lock leave it alone.
            if (state_q == ARB_IDLE) begin
                rr_ptr_d = (g_idx == IDX_W'(NUM_REQ - 1)) ? '0 : g_idx + IDX_W'(1);
            end
            if (g_lock) begin
                state_d = ARB_LOCKED;
                owner_d = g_idx;
            end else begin
                state_d = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            rsp_pend_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            rsp_pend_q <= rsp_pend_d;
        end
    end

    assign req_ready  = grant;
    assign ram_enable = xfer;
    assign rsp_valid  = rsp_pend_q;
    assign rsp_rdata  = ram_rdata;
    assign dbg_state  = state_q;
    assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter with a 2-requester and a
// 4-requester instance, each in front of a registered read-first 512x32 RAM.
module tb_ram_arbiter;
    import ram_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- 2-requester instance ----------------
    logic [1:0]  v2, r2, we2, lk2, rv2;
    logic [17:0] a2;
    logic [63:0] wd2;
    logic [31:0] rd2, ram_rd2, ram_wd2;
    logic        en2, rwe2;
    logic [8:0]  ra2;
    arb_state_e  st2;
    logic [1:0]  ptr2;
    logic [31:0] mem2 [0:511];

    ram_arbiter #(.NUM_REQ(2)) dut2 (
        .clock(clock), .reset(reset),
        .req_valid(v2), .req_ready(r2), .req_we(we2), .req_lock(lk2),
        .req_addr(a2), .req_wdata(wd2),
        .rsp_valid(rv2), .rsp_rdata(rd2),
        .ram_enable(en2), .ram_we(rwe2), .ram_addr(ra2), .ram_wdata(ram_wd2),
        .ram_rdata(ram_rd2), .dbg_state(st2), .dbg_rr_ptr(ptr2)
    );

    always_ff @(posedge clock) begin
        if (en2) begin
            ram_rd2 <= mem2[ra2];
            if (rwe2) mem2[ra2] <= ram_wd2;
        end
    end

    // ---------------- 4-requester instance ----------------
    logic [3:0]   v4, r4, we4, lk4, rv4;
    logic [35:0]  a4;
    logic [127:0] wd4;
    logic [31:0]  rd4, ram_rd4, ram_wd4;
    logic         en4, rwe4;
    logic [8:0]   ra4;
    arb_state_e   st4;
    logic [1:0]   ptr4;
    logic [31:0]  mem4 [0:511];

    ram_arbiter #(.NUM_REQ(4)) dut4 (
        .clock(clock), .reset(reset),
        .req_valid(v4), .req_ready(r4), .req_we(we4), .req_lock(lk4),
        .req_addr(a4), .req_wdata(wd4),
        .rsp_valid(rv4), .rsp_rdata(rd4),
        .ram_enable(en4), .ram_we(rwe4), .ram_addr(ra4), .ram_wdata(ram_wd4),
        .ram_rdata(ram_rd4), .dbg_state(st4), .dbg_rr_ptr(ptr4)
    );

    always_ff @(posedge clock) begin
        if (en4) begin
            ram_rd4 <= mem4[ra4];
            if (rwe4) mem4[ra4] <= ram_wd4;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request on the 2-requester instance for slot s.
    task automatic drv2(input int s, input logic we, input logic lk,
                        input logic [8:0] addr, input logic [31:0] wd);
        v2[s]            = 1'b1;
        we2[s]           = we;
        lk2[s]           = lk;
        a2[s*9 +: 9]     = addr;
        wd2[s*32 +: 32]  = wd;
    endtask

    task automatic idle2();
        v2 = '0; we2 = '0; lk2 = '0; a2 = '0; wd2 = '0;
    endtask

    // Inputs change at the falling edge; checks run 1ns later.
    task automatic next();
        @(negedge clock);
    endtask

    logic [3:0] exp_gnt4, prev_gnt4;

    initial begin
        idle2();
        v4 = '0; we4 = '0; lk4 = '0; a4 = '0; wd4 = '0;

        // ---- preload RAM contents through the arbiter ----
        repeat (2) next();
        reset = 1'b0;
        next(); drv2(0, 1'b1, 1'b0, 9'd5,   32'h0000_00A5);
        next(); drv2(0, 1'b1, 1'b0, 9'd6,   32'h0000_00B6);
        next(); drv2(0, 1'b1, 1'b0, 9'h1FF, 32'h1234_5678);
        next(); drv2(0, 1'b1, 1'b0, 9'd10,  32'h0000_0000);
        next(); idle2();

        // ---- reset behaviour with both requesters valid ----
        next(); reset = 1'b1;
        drv2(0, 1'b0, 1'b0, 9'd5, 32'h0);
        drv2(1, 1'b0, 1'b0, 9'd6, 32'h0);
        #1;
        chk("reset_ready", r2, 2'b00);
        chk("reset_enable", en2, 1'b0);
        chk("reset_rsp", rv2, 2'b00);
        chk("reset_state", st2, ARB_IDLE);
        chk("reset_ptr", ptr2, 2'd0);

        // ---- two reads right after release: r0 then r1 ----
        next(); reset = 1'b0;
        #1;
        chk("t1_ready0", r2, 2'b01);
        chk("t1_addr0", ra2, 9'd5);
        chk("t1_en0", en2, 1'b1);
        chk("t1_we0", rwe2, 1'b0);
        next(); v2[0] = 1'b0;
        #1;
        chk("t1_rsp0", rv2, 2'b01);
        chk("t1_rdata0", rd2, 32'h0000_00A5);
        chk("t1_ready1", r2, 2'b10);
        chk("t1_addr1", ra2, 9'd6);
        next(); idle2();
        #1;
        chk("t1_rsp1", rv2, 2'b10);
        chk("t1_rdata1", rd2, 32'h0000_00B6);
        chk("idle_en", en2, 1'b0);
        chk("idle_addr", ra2, 9'd0);
        chk("idle_wdata", ram_wd2, 32'h0);

        // ---- write by r1 then read of the same word by r0 ----
        next(); idle2(); drv2(1, 1'b1, 1'b0, 9'h1FF, 32'hDEAD_BEEF);
        #1;
        chk("t2_ready_w", r2, 2'b10);
        chk("t2_we", rwe2, 1'b1);
        chk("t2_wdata", ram_wd2, 32'hDEAD_BEEF);
        next(); idle2(); drv2(0, 1'b0, 1'b0, 9'h1FF, 32'h0);
        #1;
        chk("t2_rsp_w", rv2, 2'b10);
        chk("t2_old_word", rd2, 32'h1234_5678);
        chk("t2_ready_r", r2, 2'b01);
        next(); idle2();
        #1;
        chk("t2_rsp_r", rv2, 2'b01);
        chk("t2_new_word", rd2, 32'hDEAD_BEEF);

        // ---- pointer is now 1: r1 read moves it back to 0 ----
        next(); drv2(1, 1'b0, 1'b0, 9'd20, 32'h0);
        #1;
        chk("ptr_wrap_ptr", ptr2, 2'd1);
        chk("ptr_wrap_ready", r2, 2'b10);

        // ---- locked read-modify-write by r0 with r1 pending ----
        next(); drv2(0, 1'b0, 1'b1, 9'd10, 32'h0);
        #1;
        chk("lk_ready_a", r2, 2'b01);
        next(); drv2(0, 1'b1, 1'b0, 9'd10, 32'h0000_0055);
        #1;
        chk("lk_state_a", st2, ARB_LOCKED);
        chk("lk_ready_b", r2, 2'b01);
        chk("lk_we_b", rwe2, 1'b1);
        next(); v2[0] = 1'b0;
        #1;
        chk("lk_state_b", st2, ARB_IDLE);
        chk("lk_ptr_held", ptr2, 2'd1);
        chk("lk_ready_c", r2, 2'b10);
        chk("lk_rsp_b", rv2, 2'b01);

        // ---- locked owner goes quiet for three cycles ----
        next(); idle2(); drv2(0, 1'b0, 1'b1, 9'd10, 32'h0);
        #1;
        chk("q_ready_grab", r2, 2'b01);
        next(); idle2(); drv2(1, 1'b0, 1'b0, 9'd30, 32'h0);
        #1;
        chk("q_rsp", rv2, 2'b01);
        chk("q_rdata", rd2, 32'h0000_0055);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) next();
            #1;
            chk("q_ready_blocked", r2, 2'b00);
            chk("q_en_off", en2, 1'b0);
            chk("q_state", st2, ARB_LOCKED);
        end
        next(); drv2(0, 1'b0, 1'b0, 9'd10, 32'h0);
        #1;
        chk("q_release_ready", r2, 2'b01);
        chk("q_release_rsp", rv2, 2'b00);
        next(); v2[0] = 1'b0;
        #1;
        chk("q_after_state", st2, ARB_IDLE);
        chk("q_after_ready", r2, 2'b10);
        next(); idle2();

        // ---- reset with a read in flight ----
        next(); drv2(0, 1'b0, 1'b0, 9'd5, 32'h0);
        #1;
        chk("rst_grant", r2, 2'b01);
        @(posedge clock);
        #2 reset = 1'b1;
        next(); drv2(1, 1'b0, 1'b0, 9'd6, 32'h0);
        #1;
        chk("rst_rsp_drop", rv2, 2'b00);
        chk("rst_ptr", ptr2, 2'd0);
        chk("rst_state", st2, ARB_IDLE);
        next(); reset = 1'b0;
        #1;
        chk("rst_rsp_after", rv2, 2'b00);
        chk("rst_first_grant", r2, 2'b01);
        next(); idle2();
        #1;
        chk("rst_rsp_new", rv2, 2'b01);
        chk("rst_rdata_new", rd2, 32'h0000_00A5);

        // ---- 4 requesters, all valid for 8 cycles ----
        prev_gnt4 = '0;
        for (int k = 0; k < 9; k++) begin
            next();
            if (k < 8) begin
                v4 = 4'hF;
                a4 = {9'(40 + k), 9'(30 + k), 9'(20 + k), 9'(10 + k)};
            end else begin
                v4 = '0;
            end
            #1;
            if (k < 8) begin
                exp_gnt4 = 4'b0001 << (k % 4);
                chk("rr4_ready", r4, exp_gnt4);
                chk("rr4_en", en4, 1'b1);
            end else begin
                exp_gnt4 = '0;
            end
            if (k > 0) chk("rr4_rsp", rv4, prev_gnt4);
            prev_gnt4 = exp_gnt4;
        end

        next();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
